wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_wb_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and buffered load results into one
// registered register-file write port, with starvation control and hazard flags.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 5
`endif

module wb_arbiter #(
   parameter int DATA_WIDTH    = `DATA_WIDTH,
   parameter int ADDRESS_WIDTH = `ADDRESS_WIDTH,
   parameter int STARVE_MAX    = 3
) (
   input  logic                     clk,
   input  logic                     res,
   input  logic                     alu_valid,
   input  logic [ADDRESS_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0]    alu_data,
   output logic                     alu_ready,
   input  logic                     lsu_valid,
   input  logic [ADDRESS_WIDTH-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0]    lsu_data,
   output logic                     lsu_ready,
   output logic                     we,
   output logic [ADDRESS_WIDTH-1:0] A3,
   output logic [DATA_WIDTH-1:0]    WD,
   input  logic [ADDRESS_WIDTH-1:0] q_addr1,
   input  logic [ADDRESS_WIDTH-1:0] q_addr2,
   output logic                     pend1,
   output logic                     pend2
);

   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [SW-1:0] STARVE_ONE = SW'(1);
   localparam logic [ADDRESS_WIDTH-1:0] RD_ZERO = {ADDRESS_WIDTH{1'b0}};

   logic [ADDRESS_WIDTH-1:0] fifo_rd_r   [2];
   logic [DATA_WIDTH-1:0]    fifo_data_r [2];
   logic                     wr_ptr_r;
   logic                     rd_ptr_r;
   logic [1:0]               count_r;
   logic [SW-1:0]            starve_r;

   logic                     nonempty_s;
   logic                     forced_s;
   logic                     alu_grant_s;
   logic                     pop_s;
   logic                     push_s;
   logic [1:0]               entry_valid_s;
   logic [ADDRESS_WIDTH-1:0] head_rd_s;
   logic [DATA_WIDTH-1:0]    head_data_s;

   // Grant decision: a starved FIFO head pre-empts the ALU for one cycle.
   always_comb begin
      nonempty_s  = (count_r != 2'd0);
      forced_s    = (starve_r == STARVE_LIM) && nonempty_s;
      alu_grant_s = alu_valid && !forced_s;
      pop_s       = forced_s || (!alu_valid && nonempty_s);
      push_s      = lsu_valid && (count_r < 2'd2);
      alu_ready   = !forced_s;
      lsu_ready   = (count_r < 2'd2);
      head_rd_s   = fifo_rd_r[rd_ptr_r];
      head_data_s = fifo_data_r[rd_ptr_r];
   end

   // Occupancy mask of the two FIFO slots, used for hazard matching.
   always_comb begin
      entry_valid_s = 2'b00;
      case (count_r)
         2'd1:    entry_valid_s[rd_ptr_r] = 1'b1;
         2'd2:    entry_valid_s = 2'b11;
         default: entry_valid_s = 2'b00;
      endcase
   end

   // Hazard flags: any buffered or outgoing write to a non-zero queried register.
   always_comb begin
      pend1 = (q_addr1 != RD_ZERO) &&
              ((entry_valid_s[0] && (fifo_rd_r[0] == q_addr1)) ||
               (entry_valid_s[1] && (fifo_rd_r[1] == q_addr1)) ||
               (we && (A3 == q_addr1)));
      pend2 = (q_addr2 != RD_ZERO) &&
              ((entry_valid_s[0] && (fifo_rd_r[0] == q_addr2)) ||
               (entry_valid_s[1] && (fifo_rd_r[1] == q_addr2)) ||
               (we && (A3 == q_addr2)));
   end

   // LSU FIFO storage, pointers and occupancy.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         fifo_rd_r[0]   <= RD_ZERO;
         fifo_rd_r[1]   <= RD_ZERO;
         fifo_data_r[0] <= {DATA_WIDTH{1'b0}};
         fifo_data_r[1] <= {DATA_WIDTH{1'b0}};
         wr_ptr_r       <= 1'b0;
         rd_ptr_r       <= 1'b0;
         count_r        <= 2'd0;
      end else begin
         if (push_s) begin
            fifo_rd_r[wr_ptr_r]   <= lsu_rd;
            fifo_data_r[wr_ptr_r] <= lsu_data;
            wr_ptr_r              <= ~wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Registered write port; rd==0 entries are consumed without a write strobe.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         we <= 1'b0;
         A3 <= RD_ZERO;
         WD <= {DATA_WIDTH{1'b0}};
      end else if (alu_grant_s) begin
         we <= (alu_rd != RD_ZERO);
         A3 <= alu_rd;
         WD <= alu_data;
      end else if (pop_s) begin
         we <= (head_rd_s != RD_ZERO);
         A3 <= head_rd_s;
         WD <= head_data_s;
      end else begin
         we <= 1'b0;
      end
   end

   // Counts consecutive ALU wins while loads wait.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         starve_r <= {SW{1'b0}};
      end else if (pop_s || !nonempty_s) begin
         starve_r <= {SW{1'b0}};
      end else if (alu_grant_s) begin
         starve_r <= starve_r + STARVE_ONE;
      end else begin
         starve_r <= starve_r;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed per-cycle vectors push expected
// writes; a forked monitor pops and compares whenever we is high.
module tb_wb_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          res;
   logic          alu_valid;
   logic [AW-1:0] alu_rd;
   logic [DW-1:0] alu_data;
   logic          alu_ready;
   logic          lsu_valid;
   logic [AW-1:0] lsu_rd;
   logic [DW-1:0] lsu_data;
   logic          lsu_ready;
   logic          we;
   logic [AW-1:0] A3;
   logic [DW-1:0] WD;
   logic [AW-1:0] q_addr1;
   logic [AW-1:0] q_addr2;
   logic          pend1;
   logic          pend2;

   wb_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STARVE_MAX(3)) dut (
      .clk(clk), .res(res),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .we(we), .A3(A3), .WD(WD),
      .q_addr1(q_addr1), .q_addr2(q_addr2), .pend1(pend1), .pend2(pend2)
   );

   always #5 clk = ~clk;

   int            total = 0;
   int            bad   = 0;
   logic [AW+DW-1:0] exp_q [$];
   logic [AW+DW-1:0] lsu_q [$];
   logic [DW-1:0] alu_d;
   logic [DW-1:0] lsu_d;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic monitor();
      logic [AW+DW-1:0] e;
      forever begin
         @(negedge clk);
         if (res === 1'b1 && we === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: got A3=%0d WD=%0h expected no write", A3, WD);
            end else begin
               e = exp_q.pop_front();
               chk("write_A3", 32'(A3), 32'(e[AW+DW-1:DW]));
               chk("write_WD", WD, e[DW-1:0]);
            end
         end
      end
   endtask

   // One cycle: drive offers, check readies, record expected write (w: 0 none, 1 ALU, 2 next LSU).
   task automatic cyc(input logic av, input logic [AW-1:0] ard, input logic lv,
                      input logic [AW-1:0] lrd, input logic ar, input logic lr, input int w);
      logic [AW+DW-1:0] e;
      alu_valid = av; alu_rd = ard; alu_data = alu_d;
      lsu_valid = lv; lsu_rd = lrd; lsu_data = lsu_d;
      #1;
      chk("alu_ready", 32'(alu_ready), 32'(ar));
      chk("lsu_ready", 32'(lsu_ready), 32'(lr));
      if (lv && lr) lsu_q.push_back({lrd, lsu_d});
      if (w == 1) begin
         if (ard != 5'd0) exp_q.push_back({ard, alu_d});
      end else if (w == 2) begin
         if (lsu_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL lsu_model: got empty model queue expected an entry");
         end else begin
            e = lsu_q.pop_front();
            if (e[AW+DW-1:DW] != 5'd0) exp_q.push_back(e);
         end
      end
      alu_d = alu_d + 32'd1;
      lsu_d = lsu_d + 32'd1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      res = 1'b1; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
      lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
      q_addr1 = 5'd5; q_addr2 = 5'd7;
      alu_d = 32'hA000_0000; lsu_d = 32'hB000_0000;
      fork
         monitor();
      join_none
      #2 res = 1'b0;
      #1;
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_A3", 32'(A3), 32'd0);
      chk("rst_WD", WD, 32'd0);
      chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
      chk("rst_alu_ready", 32'(alu_ready), 32'd1);
      chk("rst_pend1", 32'(pend1), 32'd0);
      chk("rst_pend2", 32'(pend2), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      res = 1'b1;

      // ALU latency 1
      alu_d = 32'hDEADBEEF;
      cyc(1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 1'b1, 1);
      chk("alu_we", 32'(we), 32'd1);
      chk("alu_A3", 32'(A3), 32'd5);
      chk("alu_WD", WD, 32'hDEADBEEF);
      cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 0);
      chk("alu_we_drop", 32'(we), 32'd0);

      // LSU latency 2 with hazard flag
      q_addr1 = 5'd7; q_addr2 = 5'd9; lsu_d = 32'h11;
      cyc(1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 1'b1, 0);
      chk("lsu_we_c2", 32'(we), 32'd0);
      chk("lsu_pend1_c2", 32'(pend1), 32'd1);
      chk("lsu_pend2_c2", 32'(pend2), 32'd0);
      cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 2);
      chk("lsu_we_c3", 32'(we), 32'd1);
      chk("lsu_A3_c3", 32'(A3), 32'd7);
      chk("lsu_WD_c3", WD, 32'h11);
      chk("lsu_pend1_c3", 32'(pend1), 32'd1);
      cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 0);
      chk("lsu_pend1_c4", 32'(pend1), 32'd0);

      // Starvation: ALU held high, forced pop after three ALU wins
      cyc(1'b1, 5'd1, 1'b1, 5'd10, 1'b1, 1'b1, 1);
      cyc(1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b1, 1);
      cyc(1'b1, 5'd3, 1'b0, 5'd0,  1'b1, 1'b0, 1);
      cyc(1'b1, 5'd4, 1'b0, 5'd0,  1'b1, 1'b0, 1);
      cyc(1'b1, 5'd5, 1'b0, 5'd0,  1'b0, 1'b0, 2);
      cyc(1'b1, 5'd5, 1'b0, 5'd0,  1'b1, 1'b1, 1);
      cyc(1'b1, 5'd6, 1'b0, 5'd0,  1'b1, 1'b1, 1);
      cyc(1'b1, 5'd7, 1'b0, 5'd0,  1'b1, 1'b1, 1);
      cyc(1'b1, 5'd8, 1'b0, 5'd0,  1'b0, 1'b1, 2);
      cyc(1'b1, 5'd8, 1'b0, 5'd0,  1'b1, 1'b1, 1);
      cyc(1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 1'b1, 0);

      // FIFO full backpressure, ready returns the cycle after a pop
      cyc(1'b1, 5'd1, 1'b1, 5'd12, 1'b1, 1'b1, 1);
      cyc(1'b1, 5'd2, 1'b1, 5'd13, 1'b1, 1'b1, 1);
      cyc(1'b1, 5'd3, 1'b1, 5'd14, 1'b1, 1'b0, 1);
      cyc(1'b1, 5'd4, 1'b1, 5'd14, 1'b1, 1'b0, 1);
      cyc(1'b1, 5'd5, 1'b1, 5'd14, 1'b0, 1'b0, 2);
      cyc(1'b1, 5'd5, 1'b1, 5'd14, 1'b1, 1'b1, 1);
      cyc(1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 1'b0, 2);
      cyc(1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 1'b1, 2);
      cyc(1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 1'b1, 0);

      // rd == 0 offers are consumed silently
      q_addr1 = 5'd0;
      cyc(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1);
      chk("rd0_we_a", 32'(we), 32'd0);
      chk("rd0_pend1", 32'(pend1), 32'd0);
      cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 2);
      chk("rd0_we_b", 32'(we), 32'd0);
      cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 0);

      // Reset mid-operation with a full FIFO and a live write
      q_addr1 = 5'd15; q_addr2 = 5'd16;
      cyc(1'b1, 5'd20, 1'b1, 5'd15, 1'b1, 1'b1, 1);
      cyc(1'b1, 5'd21, 1'b1, 5'd16, 1'b1, 1'b1, 0);
      chk("pre_rst_we", 32'(we), 32'd1);
      chk("pre_rst_A3", 32'(A3), 32'd21);
      chk("pre_rst_pend1", 32'(pend1), 32'd1);
      chk("pre_rst_pend2", 32'(pend2), 32'd1);
      res = 1'b0;
      #1;
      chk("mid_rst_we", 32'(we), 32'd0);
      chk("mid_rst_A3", 32'(A3), 32'd0);
      chk("mid_rst_WD", WD, 32'd0);
      chk("mid_rst_lsu_ready", 32'(lsu_ready), 32'd1);
      chk("mid_rst_alu_ready", 32'(alu_ready), 32'd1);
      chk("mid_rst_pend1", 32'(pend1), 32'd0);
      lsu_q.delete();
      alu_valid = 1'b0; lsu_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      res = 1'b1;
      cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 0);
      chk("post_rst_we_a", 32'(we), 32'd0);
      cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 0);
      chk("post_rst_we_b", 32'(we), 32'd0);
      chk("post_rst_pend1", 32'(pend1), 32'd0);
      cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 0);

      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
